// File: rtl/count_one_seq_pkg.sv
// Shared types and elaboration helpers for the sequential ones-count decoder.
package count_one_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } count_one_seq_state_t;

  // Index counters need at least one bit even when there is a single chunk.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_one_chunk.sv
// Combinational popcount of one CHUNK-bit slice of the mask.
module count_one_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0]       bits_i,
  output logic [$clog2(CHUNK):0] cnt_o
);

  localparam int CNT_W = $clog2(CHUNK) + 1;

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CHUNK; i++) cnt_o = cnt_o + CNT_W'(bits_i[i]);
  end

endmodule

// File: rtl/count_one_seq.sv
// Multi-cycle mask-to-count decoder, CHUNK bits per cycle, valid/ready on both sides.
// Optional thermometer-code check on the accepted mask: COUNT_ONE_THERMO_CHECK_EN.
module count_one_seq
  import count_one_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [$clog2(WIDTH):0] data_out,
  output logic                   out_valid,
`ifdef COUNT_ONE_THERMO_CHECK_EN
  output logic                   err,
`endif
  input  logic                   out_ready
);

  localparam int CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(CHUNKS);
  localparam int OUT_W  = $clog2(WIDTH) + 1;
  localparam int CNT_W  = $clog2(CHUNK) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("count_one_seq: WIDTH must be a multiple of CHUNK");
  end

  count_one_seq_state_t state_q, state_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [OUT_W-1:0]     dout_q, dout_d;
  logic [OUT_W-1:0]     sum;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     chunk_cnt;

  // The mask shifts right each BUSY cycle, so chunk[idx] always sits in the low bits.
  count_one_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits_i (sh_q[CHUNK-1:0]),
    .cnt_o  (chunk_cnt)
  );

`ifdef COUNT_ONE_THERMO_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] mask_inc;
  // Wraps to zero for all-ones, which is a legal thermometer code.
  assign mask_inc = data_in + WIDTH'(1);
  assign err      = err_q;
`endif

  assign sum = acc_q + OUT_W'(chunk_cnt);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
`ifdef COUNT_ONE_THERMO_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = data_in;
          acc_d   = '0;
          idx_d   = '0;
`ifdef COUNT_ONE_THERMO_CHECK_EN
          err_d   = |(data_in & mask_inc);
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = sum;
        sh_d  = sh_q >> CHUNK;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          dout_d  = sum;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
`ifdef COUNT_ONE_THERMO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
`ifdef COUNT_ONE_THERMO_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_count_one_seq.sv
// Directed bench for count_one_seq: default build plus CHUNK=1 and CHUNK=8 variants.
module tb_count_one_seq;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0][7:0] din;
  logic [2:0]      iv, ir, ov, ordy, er;
  logic [2:0][3:0] dout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  count_one_seq #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst(rst), .data_in(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .data_out(dout[0]), .out_valid(ov[0]),
`ifdef COUNT_ONE_THERMO_CHECK_EN
    .err(er[0]),
`endif
    .out_ready(ordy[0]));

  count_one_seq #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .data_out(dout[1]), .out_valid(ov[1]),
`ifdef COUNT_ONE_THERMO_CHECK_EN
    .err(er[1]),
`endif
    .out_ready(ordy[1]));

  count_one_seq #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst(rst), .data_in(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .data_out(dout[2]), .out_valid(ov[2]),
`ifdef COUNT_ONE_THERMO_CHECK_EN
    .err(er[2]),
`endif
    .out_ready(ordy[2]));

`ifndef COUNT_ONE_THERMO_CHECK_EN
  assign er = '0;
`endif

  typedef struct {
    logic [7:0] mask;
    int         cnt;
    logic       err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction on DUT d with out_ready already high.
  task automatic run_txn(input int d, input logic [7:0] m, input int exp_cnt,
                         input logic exp_err, input int lat, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(ir[d]), 1);
    din[d] = m;
    iv[d]  = 1'b1;
    @(posedge clk);
    #1 iv[d] = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ov[d]) seen = 1;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " count"}, 32'(dout[d]), 32'(exp_cnt));
`ifdef COUNT_ONE_THERMO_CHECK_EN
    check({tag, " err"}, 32'(er[d]), 32'(exp_err));
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid drop"}, 32'(ov[d]), 0);
    check({tag, " in_ready back"}, 32'(ir[d]), 1);
  endtask

  initial begin
    vec_t vecs[13];
    logic [7:0] m;
    logic [3:0] held;

    vecs[0]  = '{8'h00, 0, 1'b0};
    vecs[1]  = '{8'h01, 1, 1'b0};
    vecs[2]  = '{8'h03, 2, 1'b0};
    vecs[3]  = '{8'h07, 3, 1'b0};
    vecs[4]  = '{8'h0F, 4, 1'b0};
    vecs[5]  = '{8'h1F, 5, 1'b0};
    vecs[6]  = '{8'h3F, 6, 1'b0};
    vecs[7]  = '{8'h7F, 7, 1'b0};
    vecs[8]  = '{8'hFF, 8, 1'b0};
    vecs[9]  = '{8'hA5, 4, 1'b1};
    vecs[10] = '{8'h80, 1, 1'b1};
    vecs[11] = '{8'h3C, 4, 1'b1};
    vecs[12] = '{8'h06, 2, 1'b1};

    rst  = 1'b1;
    din  = '0;
    iv   = '0;
    ordy = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready low", 32'(ir[0]), 0);
    check("reset out_valid", 32'(ov[0]), 0);
    check("reset data_out", 32'(dout[0]), 0);
    check("reset err", 32'(er[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(ir[0]), 1);

    foreach (vecs[i])
      run_txn(0, vecs[i].mask, vecs[i].cnt, vecs[i].err, 4, $sformatf("vec%0d", i));

    // Consumer stalls 5 cycles in DONE.
    ordy[0] = 1'b0;
    @(negedge clk);
    din[0] = 8'hA5;
    iv[0]  = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    for (int c = 0; c < 40 && !ov[0]; c++) @(negedge clk);
    check("stall reached DONE", 32'(ov[0]), 1);
    held = dout[0];
    check("stall count", 32'(held), 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d out_valid", c), 32'(ov[0]), 1);
      check($sformatf("stall%0d data_out", c), 32'(dout[0]), 4);
      check($sformatf("stall%0d in_ready", c), 32'(ir[0]), 0);
`ifdef COUNT_ONE_THERMO_CHECK_EN
      check($sformatf("stall%0d err", c), 32'(er[0]), 1);
`endif
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall release out_valid", 32'(ov[0]), 0);
    check("stall release in_ready", 32'(ir[0]), 1);

    // Reset during the second BUSY cycle discards the mask.
    din[0] = 8'hFF;
    iv[0]  = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst in_ready low", 32'(ir[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(ov[0]), 0);
    check("rst data_out", 32'(dout[0]), 0);
    check("rst in_ready", 32'(ir[0]), 1);
    check("rst err", 32'(er[0]), 0);
    run_txn(0, 8'h0F, 4, 1'b0, 4, "after_rst");

    // Narrow and full-width chunk builds against a reference popcount.
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      run_txn(1, m, $countones(m), |(m & (m + 8'd1)), 8, $sformatf("c1_%0d", i));
      m = 8'($urandom);
      run_txn(2, m, $countones(m), |(m & (m + 8'd1)), 1, $sformatf("c8_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
